// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the program counter, issues one instruction-memory
// request at a time, and hands pc/instruction pairs to decode through a
// valid/ready slot backed by a one-entry skid buffer. Redirects from execute
// kill the in-flight path, including a response that is still on its way.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          PC_STEP  = 4
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemReady,
    input  logic        imemRespValid,
    input  logic [31:0] imemRespData,
    input  logic        redirectValid,
    input  logic [31:0] redirectPc,
    input  logic        decodeReady,
    output logic        fetchValid,
    output logic [31:0] fetchPc,
    output logic [31:0] fetchInstruction
);

    localparam logic [31:0] STEP = 32'(PC_STEP);

    typedef enum logic [1:0] {
        ISSUE = 2'd0,
        WAIT  = 2'd1,
        STALL = 2'd2,
        DROP  = 2'd3
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] req_pc_reg, req_pc_next;
    logic        slot_valid_reg, slot_valid_next;
    logic [31:0] slot_pc_reg, slot_pc_next;
    logic [31:0] slot_data_reg, slot_data_next;
    logic        skid_valid_reg, skid_valid_next;
    logic [31:0] skid_pc_reg, skid_pc_next;
    logic [31:0] skid_data_reg, skid_data_next;

    logic accept;
    logic consume;
    logic resp_take;
    logic load_slot_resp;
    logic load_skid;
    logic unload_skid;

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= ISSUE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; a redirect overrides every other transition
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ISSUE: begin
                if (!redirectValid && imemReady) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (redirectValid) begin
                    // A response landing in the redirect cycle is simply
                    // dropped; otherwise it is still owed and must be eaten.
                    state_next = imemRespValid ? ISSUE : DROP;
                end else if (imemRespValid) begin
                    state_next = (!slot_valid_reg || consume) ? ISSUE : STALL;
                end
            end
            STALL: begin
                if (redirectValid || consume) begin
                    state_next = ISSUE;
                end
            end
            DROP: begin
                // The killed response retires the outstanding request even if
                // another redirect arrives alongside it, so nothing stays owed.
                if (imemRespValid) begin
                    state_next = ISSUE;
                end
            end
            default: state_next = ISSUE;
        endcase
    end

    // Output and datapath-control decode
    always_comb begin
        imemReq        = reset && (state_reg == ISSUE) && !redirectValid;
        imemAddr       = pc_reg;
        accept         = imemReq && imemReady;
        consume        = slot_valid_reg && decodeReady;
        resp_take      = (state_reg == WAIT) && imemRespValid && !redirectValid;
        load_slot_resp = resp_take && (!slot_valid_reg || consume);
        load_skid      = resp_take && slot_valid_reg && !consume;
        unload_skid    = (state_reg == STALL) && consume && !redirectValid;
    end

    // Next values for pc, request tag, output slot and skid buffer
    always_comb begin
        pc_next         = pc_reg;
        req_pc_next     = req_pc_reg;
        slot_valid_next = slot_valid_reg;
        slot_pc_next    = slot_pc_reg;
        slot_data_next  = slot_data_reg;
        skid_valid_next = skid_valid_reg;
        skid_pc_next    = skid_pc_reg;
        skid_data_next  = skid_data_reg;

        if (redirectValid) begin
            pc_next = {redirectPc[31:2], 2'b00};
        end else if (accept) begin
            pc_next = pc_reg + STEP;
        end

        if (accept) begin
            req_pc_next = pc_reg;
        end

        if (redirectValid) begin
            slot_valid_next = 1'b0;
        end else if (load_slot_resp) begin
            slot_valid_next = 1'b1;
            slot_pc_next    = req_pc_reg;
            slot_data_next  = imemRespData;
        end else if (unload_skid) begin
            slot_valid_next = 1'b1;
            slot_pc_next    = skid_pc_reg;
            slot_data_next  = skid_data_reg;
        end else if (consume) begin
            slot_valid_next = 1'b0;
        end

        if (redirectValid || unload_skid) begin
            skid_valid_next = 1'b0;
        end else if (load_skid) begin
            skid_valid_next = 1'b1;
            skid_pc_next    = req_pc_reg;
            skid_data_next  = imemRespData;
        end
    end

    // Datapath registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_reg         <= RESET_PC;
            req_pc_reg     <= 32'h0;
            slot_valid_reg <= 1'b0;
            slot_pc_reg    <= 32'h0;
            slot_data_reg  <= 32'h0;
            skid_valid_reg <= 1'b0;
            skid_pc_reg    <= 32'h0;
            skid_data_reg  <= 32'h0;
        end else begin
            pc_reg         <= pc_next;
            req_pc_reg     <= req_pc_next;
            slot_valid_reg <= slot_valid_next;
            slot_pc_reg    <= slot_pc_next;
            slot_data_reg  <= slot_data_next;
            skid_valid_reg <= skid_valid_next;
            skid_pc_reg    <= skid_pc_next;
            skid_data_reg  <= skid_data_next;
        end
    end

    assign fetchValid       = slot_valid_reg;
    assign fetchPc          = slot_pc_reg;
    assign fetchInstruction = slot_data_reg;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: a cycle-by-cycle vector table
// followed by a hand-written redirect-while-stalled sequence.
module tb_instruction_fetch_unit;

    logic        clock;
    logic        reset;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemReady;
    logic        imemRespValid;
    logic [31:0] imemRespData;
    logic        redirectValid;
    logic [31:0] redirectPc;
    logic        decodeReady;
    logic        fetchValid;
    logic [31:0] fetchPc;
    logic [31:0] fetchInstruction;

    int checks_cnt = 0;
    int fail_cnt   = 0;

    instruction_fetch_unit #(
        .RESET_PC(32'h0000_0000),
        .PC_STEP (4)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .imemReq         (imemReq),
        .imemAddr        (imemAddr),
        .imemReady       (imemReady),
        .imemRespValid   (imemRespValid),
        .imemRespData    (imemRespData),
        .redirectValid   (redirectValid),
        .redirectPc      (redirectPc),
        .decodeReady     (decodeReady),
        .fetchValid      (fetchValid),
        .fetchPc         (fetchPc),
        .fetchInstruction(fetchInstruction)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        rv;
        logic [31:0] rdata;
        logic        dr;
        logic        redir;
        logic [31:0] rpc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_fv;
        logic [31:0] e_fpc;
        logic [31:0] e_fi;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst, logic rdy, logic rv, logic [31:0] rdata,
                                logic dr, logic redir, logic [31:0] rpc,
                                logic e_req, logic [31:0] e_addr, logic e_fv,
                                logic [31:0] e_fpc, logic [31:0] e_fi);
        vec_t v;
        v.rst = rst; v.rdy = rdy; v.rv = rv; v.rdata = rdata;
        v.dr = dr; v.redir = redir; v.rpc = rpc;
        v.e_req = e_req; v.e_addr = e_addr; v.e_fv = e_fv;
        v.e_fpc = e_fpc; v.e_fi = e_fi;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s got=%08h exp=%08h", name, got, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, then let outputs settle
    task automatic drive(input logic rst, input logic rdy, input logic rv, input logic [31:0] rdata,
                         input logic dr, input logic redir, input logic [31:0] rpc);
        @(negedge clock);
        reset         = rst;
        imemReady     = rdy;
        imemRespValid = rv;
        imemRespData  = rdata;
        decodeReady   = dr;
        redirectValid = redir;
        redirectPc    = rpc;
        #1;
    endtask

    initial begin
        reset         = 1'b0;
        imemReady     = 1'b0;
        imemRespValid = 1'b0;
        imemRespData  = 32'h0;
        decodeReady   = 1'b0;
        redirectValid = 1'b0;
        redirectPc    = 32'h0;

        //               rst rdy rv rdata          dr redir rpc            req addr           fv  fpc            fi
        // Reset, then straight-line fetch with single-cycle memory
        vecs.push_back(mk(0, 1, 0, 32'h0,          1, 0, 32'h0,          0, 32'h0,          0, 32'h0,          32'h0));
        vecs.push_back(mk(1, 1, 0, 32'h0,          1, 0, 32'h0,          1, 32'h0,          0, 32'h0,          32'h0));
        vecs.push_back(mk(1, 0, 1, 32'h13,         1, 0, 32'h0,          0, 32'h4,          0, 32'h0,          32'h0));
        vecs.push_back(mk(1, 1, 0, 32'h0,          1, 0, 32'h0,          1, 32'h4,          1, 32'h0,          32'h13));
        vecs.push_back(mk(1, 0, 1, 32'h13,         1, 0, 32'h0,          0, 32'h8,          0, 32'h0,          32'h13));
        vecs.push_back(mk(1, 1, 0, 32'h0,          1, 0, 32'h0,          1, 32'h8,          1, 32'h4,          32'h13));
        vecs.push_back(mk(1, 0, 1, 32'h13,         1, 0, 32'h0,          0, 32'hC,          0, 32'h4,          32'h13));
        vecs.push_back(mk(1, 0, 0, 32'h0,          1, 0, 32'h0,          1, 32'hC,          1, 32'h8,          32'h13));
        // Reset again, then back-pressure into STALL and release
        vecs.push_back(mk(0, 0, 0, 32'h0,          1, 0, 32'h0,          0, 32'h0,          0, 32'h0,          32'h0));
        vecs.push_back(mk(1, 1, 0, 32'h0,          0, 0, 32'h0,          1, 32'h0,          0, 32'h0,          32'h0));
        vecs.push_back(mk(1, 0, 1, 32'h13,         0, 0, 32'h0,          0, 32'h4,          0, 32'h0,          32'h0));
        vecs.push_back(mk(1, 1, 0, 32'h0,          0, 0, 32'h0,          1, 32'h4,          1, 32'h0,          32'h13));
        vecs.push_back(mk(1, 0, 1, 32'hDEADBEEF,   0, 0, 32'h0,          0, 32'h8,          1, 32'h0,          32'h13));
        vecs.push_back(mk(1, 1, 0, 32'h0,          0, 0, 32'h0,          0, 32'h8,          1, 32'h0,          32'h13));
        vecs.push_back(mk(1, 1, 0, 32'h0,          1, 0, 32'h0,          0, 32'h8,          1, 32'h0,          32'h13));
        vecs.push_back(mk(1, 1, 0, 32'h0,          0, 0, 32'h0,          1, 32'h8,          1, 32'h4,          32'hDEADBEEF));
        vecs.push_back(mk(1, 0, 0, 32'h0,          1, 0, 32'h0,          0, 32'hC,          1, 32'h4,          32'hDEADBEEF));
        // Redirect while waiting for pc 0x8; its response turns up 3 cycles later
        vecs.push_back(mk(1, 0, 0, 32'h0,          1, 1, 32'h100,        0, 32'hC,          0, 32'h4,          32'hDEADBEEF));
        vecs.push_back(mk(1, 1, 0, 32'h0,          1, 0, 32'h0,          0, 32'h100,        0, 32'h4,          32'hDEADBEEF));
        vecs.push_back(mk(1, 1, 0, 32'h0,          1, 0, 32'h0,          0, 32'h100,        0, 32'h4,          32'hDEADBEEF));
        vecs.push_back(mk(1, 1, 1, 32'h11111111,   1, 0, 32'h0,          0, 32'h100,        0, 32'h4,          32'hDEADBEEF));
        vecs.push_back(mk(1, 1, 0, 32'h0,          1, 0, 32'h0,          1, 32'h100,        0, 32'h4,          32'hDEADBEEF));
        vecs.push_back(mk(1, 0, 1, 32'h22222222,   1, 0, 32'h0,          0, 32'h104,        0, 32'h4,          32'hDEADBEEF));
        vecs.push_back(mk(1, 0, 0, 32'h0,          1, 0, 32'h0,          1, 32'h104,        1, 32'h100,        32'h22222222));
        // Redirect in ISSUE with imemReady high: no request, misaligned target
        vecs.push_back(mk(1, 1, 0, 32'h0,          1, 1, 32'h203,        0, 32'h104,        0, 32'h100,        32'h22222222));
        vecs.push_back(mk(1, 1, 0, 32'h0,          1, 0, 32'h0,          1, 32'h200,        0, 32'h100,        32'h22222222));
        // Reset mid-WAIT, stale response after release is ignored
        vecs.push_back(mk(0, 0, 1, 32'h33333333,   1, 0, 32'h0,          0, 32'h0,          0, 32'h0,          32'h0));
        vecs.push_back(mk(1, 0, 1, 32'h33333333,   1, 0, 32'h0,          1, 32'h0,          0, 32'h0,          32'h0));
        vecs.push_back(mk(1, 0, 0, 32'h0,          1, 0, 32'h0,          1, 32'h0,          0, 32'h0,          32'h0));
        vecs.push_back(mk(1, 1, 0, 32'h0,          1, 0, 32'h0,          1, 32'h0,          0, 32'h0,          32'h0));
        vecs.push_back(mk(1, 0, 1, 32'h44444444,   1, 0, 32'h0,          0, 32'h4,          0, 32'h0,          32'h0));
        vecs.push_back(mk(1, 0, 0, 32'h0,          1, 0, 32'h0,          1, 32'h4,          1, 32'h0,          32'h44444444));
        // PC wrap from 0xFFFFFFFC
        vecs.push_back(mk(1, 0, 0, 32'h0,          1, 1, 32'hFFFFFFFC,   0, 32'h4,          0, 32'h0,          32'h44444444));
        vecs.push_back(mk(1, 1, 0, 32'h0,          1, 0, 32'h0,          1, 32'hFFFFFFFC,   0, 32'h0,          32'h44444444));
        vecs.push_back(mk(1, 0, 1, 32'h55555555,   1, 0, 32'h0,          0, 32'h0,          0, 32'h0,          32'h44444444));
        vecs.push_back(mk(1, 0, 0, 32'h0,          0, 0, 32'h0,          1, 32'h0,          1, 32'hFFFFFFFC,   32'h55555555));
        // Redirect in WAIT coinciding with the response
        vecs.push_back(mk(1, 1, 0, 32'h0,          0, 0, 32'h0,          1, 32'h0,          1, 32'hFFFFFFFC,   32'h55555555));
        vecs.push_back(mk(1, 0, 1, 32'h66666666,   0, 1, 32'h40,         0, 32'h4,          1, 32'hFFFFFFFC,   32'h55555555));
        vecs.push_back(mk(1, 0, 0, 32'h0,          0, 0, 32'h0,          1, 32'h40,         0, 32'hFFFFFFFC,   32'h55555555));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].rdy, vecs[i].rv, vecs[i].rdata,
                  vecs[i].dr, vecs[i].redir, vecs[i].rpc);
            chk($sformatf("v%0d_req", i),   {31'h0, imemReq},    {31'h0, vecs[i].e_req});
            chk($sformatf("v%0d_addr", i),  imemAddr,            vecs[i].e_addr);
            chk($sformatf("v%0d_fv", i),    {31'h0, fetchValid}, {31'h0, vecs[i].e_fv});
            chk($sformatf("v%0d_fpc", i),   fetchPc,             vecs[i].e_fpc);
            chk($sformatf("v%0d_finst", i), fetchInstruction,    vecs[i].e_fi);
            $display("vec %0d req=%0b addr=%08h fv=%0b fpc=%08h finst=%08h",
                     i, imemReq, imemAddr, fetchValid, fetchPc, fetchInstruction);
        end

        // Redirect while STALLed: both slot and skid must be discarded
        drive(1, 1, 0, 32'h0,  0, 0, 32'h0);
        chk("stl_req0",  {31'h0, imemReq}, 32'h1);
        chk("stl_addr0", imemAddr, 32'h40);
        drive(1, 0, 1, 32'hA0, 0, 0, 32'h0);
        drive(1, 1, 0, 32'h0,  0, 0, 32'h0);
        chk("stl_fpc1",  fetchPc, 32'h40);
        chk("stl_addr1", imemAddr, 32'h44);
        drive(1, 0, 1, 32'hA4, 0, 0, 32'h0);
        drive(1, 1, 0, 32'h0,  0, 0, 32'h0);
        chk("stl_req_stall", {31'h0, imemReq}, 32'h0);
        chk("stl_fi_held",   fetchInstruction, 32'hA0);
        $display("seq stall req=%0b fv=%0b fpc=%08h", imemReq, fetchValid, fetchPc);
        drive(1, 1, 0, 32'h0,  0, 1, 32'h80);
        chk("stl_req_redir", {31'h0, imemReq}, 32'h0);
        drive(1, 0, 0, 32'h0,  1, 0, 32'h0);
        chk("stl_fv_cleared", {31'h0, fetchValid}, 32'h0);
        chk("stl_req_new",    {31'h0, imemReq}, 32'h1);
        chk("stl_addr_new",   imemAddr, 32'h80);
        drive(1, 0, 0, 32'h0,  1, 0, 32'h0);
        chk("stl_skid_gone",  {31'h0, fetchValid}, 32'h0);
        $display("seq redirect-in-stall fv=%0b addr=%08h", fetchValid, imemAddr);

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Fetch stage that produces the pc/instruction pair consumed by the fetch-to-decode pipeline register.
- Owns the program counter and issues word requests to instruction memory over a req/ready request channel plus a response-valid channel, with one request outstanding at a time.
- Presents fetched instructions to decode through a valid/ready interface with a one-entry skid buffer.
- Accepts branch/jump redirects from execute and discards any response belonging to the killed path.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- PC_STEP, 4, PC increment per accepted request.

Ports:
- clock  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- imemReq  output  1  request valid; combinational = (state==ISSUE) && !redirectValid.
- imemAddr  output  32  request address = pc.
- imemReady  input  1  memory accepts the request this cycle when imemReq && imemReady.
- imemRespValid  input  1  response data valid; arrives 1+ cycles after acceptance.
- imemRespData  input  32  instruction word.
- redirectValid  input  1  redirect from execute; highest priority.
- redirectPc  input  32  redirect target; bits [1:0] ignored and treated as 0.
- decodeReady  input  1  decode consumes the output when fetchValid && decodeReady.
- fetchValid  output  1  output slot holds a valid instruction.
- fetchPc  output  32  pc of the instruction in the output slot.
- fetchInstruction  output  32  instruction in the output slot.

Behaviour:
- Reset (reset==0, asynchronous):
  - pc=RESET_PC, state=ISSUE.
  - fetchValid=0, fetchPc=0, fetchInstruction=0.
  - Skid buffer invalid, reqPc=0.
  - imemReq=0 while reset is held.
  - Reset mid-transaction abandons the outstanding request; memory responses arriving after reset release, before any new request is accepted, are ignored in ISSUE.
- Registered state: pc, reqPc (address of the outstanding request), state in {ISSUE, WAIT, STALL, DROP}, output slot, skid buffer (valid, pc, data).
- Consume: consume = fetchValid && decodeReady, evaluated at the clock edge.
- Redirect (any state, highest priority):
  - pc<=redirectPc with [1:0] cleared; fetchValid<=0; skid cleared.
  - From WAIT with no response this cycle: next state DROP.
  - From WAIT with imemRespValid this cycle: the response is discarded; next state ISSUE.
  - From ISSUE, STALL: next state ISSUE.
  - From DROP: stay in DROP; pc updated.
  - imemReq is gated low in the redirect cycle, so no wrong-path request is accepted.
- ISSUE:
  - imemReq=1. If imemReady: reqPc<=pc, pc<=pc+PC_STEP (32-bit wrap, 0xFFFFFFFC+4=0), next state WAIT.
  - A consume in ISSUE clears fetchValid.
- WAIT, on imemRespValid:
  - If output slot empty or consume: slot<= {reqPc, data}, fetchValid<=1, next state ISSUE.
  - Else: skid<= {reqPc, data}, next state STALL.
  - WAIT with no response: a consume clears fetchValid.
- STALL:
  - No requests issued.
  - On consume: slot<=skid, skid invalid, next state ISSUE.
  - The slot never empties while the skid is full.
- DROP:
  - No requests issued.
  - The first imemRespValid is discarded; next state ISSUE.
- Ordering: instructions are presented in request order. No duplicates; no loss except for redirect-killed instructions.
- Throughput: with single-cycle memory and decodeReady=1, one instruction per 2 cycles. Fetch-to-output latency = response cycle + 1 edge.
- Stability: fetchPc/fetchInstruction are stable while fetchValid && !decodeReady.

Test Plan:
- Reset release, imemReady=1, response 1 cycle after accept with data 0x00000013, decodeReady=1 -> imemAddr sequence 0x0, 0x4, 0x8. fetchValid pulses with fetchPc 0x0, 0x4, 0x8, each one edge after its response.
- decodeReady=0 after first output (pc 0x0 held), second response 0xDEADBEEF arrives -> state STALL, imemReq=0, output stays pc 0x0. Raise decodeReady -> output becomes pc 0x4 / 0xDEADBEEF next edge, then fetch resumes at 0x8.
- Redirect to 0x100 while in WAIT for pc 0x8, response arrives 3 cycles later -> response discarded, fetchValid=0. Next request address 0x100; next output fetchPc=0x100.
- Redirect to 0x203 in ISSUE with imemReady=1 in the same cycle -> imemReq low that cycle, no request accepted. Next request address 0x200.
- Assert reset mid-WAIT, then release -> all outputs zero during reset; first request after release has address RESET_PC; a stale response before acceptance is ignored.
- pc=0xFFFFFFFC accepted -> next imemAddr 0x00000000.
